display_output_unit: RTL
========================

// Module: display_output_unit
// PURPOSE
//  Sequential successor to the combinational sign/BCD output path. Captures a
//  two's-complement operand (or a preformatted BCD word) on a load pulse, then
//  converts it iteratively (shift-add-3). Drives DIGITS seven-segment displays
//  with sign, leading-zero blanking and overflow indication, plus busy/valid status.
// PARAMETERS
//  WIDTH     8  operand width, two's complement
//  DIGITS    4  display count; digit DIGITS-1 is the sign position, the rest hold magnitude
//  BLANK_LZ  1  1 = blank leading zeros of the magnitude; ones digit is never blanked
// PORTS
//  clk     in   1          rising-edge clock
//  reset   in   1          asynchronous, active-high
//  toggle  in   1          source select sampled with load: 0 = bin_in, 1 = bcd_in
//  load    in   1          start request; honoured only in IDLE
//  bin_in  in   WIDTH      signed operand
//  bcd_in  in   4*DIGITS   nibble codes: 0-9 digit, 0xA minus, any other code blank
//  busy    out  1          capture/conversion in progress
//  valid   out  1          seg holds a completed result; level signal
//  ovf     out  1          last binary result did not fit the magnitude digits
//  seg     out  7*DIGITS   active-low; seg[7i+6:7i] = digit i, bit0=a .. bit6=g
// BEHAVIOUR
//  Reset (asynchronous): state=IDLE; busy=0; valid=0; ovf=0; seg=all 1s (blank).
//  - Reset mid-operation aborts the operation. No stale result is shown afterwards.
//  States: IDLE, CONV, LATCH.
//  IDLE + load, toggle=0: capture neg=bin_in[WIDTH-1] and mag=|bin_in| (WIDTH-bit
//    unsigned). -2^(WIDTH-1) gives mag=2^(WIDTH-1). Clear the BCD accumulator,
//    go to CONV, busy=1, valid=0.
//  IDLE + load, toggle=1: capture bcd_in, go to LATCH, busy=1, valid=0.
//  CONV: one shift per edge. Add 3 to each BCD nibble >=5, then shift left with
//    the MSB of mag. Exactly WIDTH edges; the accumulator is sized for the full
//    WIDTH range. After the WIDTH-th shift, go to LATCH.
//  LATCH: on the next edge, update seg and ovf, set valid=1, busy=0, go to IDLE.
//  Latency, counted from the edge that samples load: binary mode WIDTH+1 edges
//    (busy high WIDTH+1 cycles); passthrough mode 1 edge.
//  Binary formatting:
//  - Digit DIGITS-1 shows minus if neg, blank otherwise.
//  - Digits DIGITS-2..0 show the low BCD nibbles.
//  - BLANK_LZ=1: zeros above the highest nonzero magnitude digit are blanked.
//  - ovf=1 when any accumulator nibble at index >= DIGITS-1 is nonzero. In that
//    case every digit shows minus, including the sign position.
//  Passthrough formatting: each nibble decoded directly. No blanking is applied
//    and ovf is cleared.
//  load outside IDLE is ignored: no queueing, no restart. toggle/bin_in/bcd_in
//    are only sampled on the accepting edge.
//  seg and ovf change only on the LATCH edge or reset, so the display never
//    shows intermediate values. valid stays high until the next accepted load.
//  Segment codes, active-low gfedcba: 0=1000000 1=1111001 2=0100100 3=0110000
//    4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000
//    minus=0111111 blank=1111111
// TESTING (WIDTH=8, DIGITS=4 unless stated)
//  1. bin_in=8'd123, toggle=0, load 1 cycle -> busy high 9 cycles, then valid=1,
//     seg=" 123", ovf=0.
//  2. bin_in=8'h80 -> "-128". bin_in=8'hF9 -> "-  7" (BLANK_LZ=1) and "-007"
//     (BLANK_LZ=0). bin_in=0 -> "   0".
//  3. toggle=1, bcd_in=16'hA042, load -> valid and seg="-042" one edge later;
//     busy high exactly 1 cycle.
//  4. DIGITS=3, bin_in=8'd150 -> seg="---", ovf=1. Then bin_in=8'd99 ->
//     seg=" 99", ovf=0.
//  5. load held high continuously, bin_in changed during CONV -> the first
//     value completes unchanged, then the next is accepted from IDLE.
//  6. reset asserted on the 4th CONV cycle -> busy=0, valid=0, seg blank
//     immediately. The next load converts correctly.

Source files
------------

// File: rtl/display_output_unit.sv
// Sequential sign/BCD display driver: captures a two's-complement operand or a
// preformatted BCD word, converts by shift-add-3 and drives active-low 7-segment digits.
module display_output_unit #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIGITS   = 4,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  toggle,
  input  logic                  load,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  valid,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   seg
);

  // Enough BCD digits for any WIDTH-bit unsigned magnitude, and never fewer than the display
  localparam int unsigned MAG_D = (WIDTH * 301) / 1000 + 1;
  localparam int unsigned ACC_D = (MAG_D > DIGITS) ? MAG_D : DIGITS;
  localparam int unsigned ACC_W = 4 * ACC_D;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned SEG_W = 7 * DIGITS;
  localparam int unsigned OVF_W = 4 * (ACC_D - DIGITS + 1);

  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t               state;
  state_t               state_d;
  logic                 neg;
  logic                 mode_bcd;
  logic [WIDTH-1:0]     mag;
  logic [WIDTH-1:0]     mag_in_c;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_adj_c;
  logic [ACC_W-1:0]     acc_sh_c;
  logic [4*DIGITS-1:0]  bcd_q;
  logic [CNT_W-1:0]     cnt;
  logic [SEG_W-1:0]     seg_d_c;
  logic                 ovf_d_c;
  logic                 lead_c;
  logic [3:0]           nib_adj_c;
  logic [3:0]           nib_fmt_c;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      4'hA:    r = SEG_MINUS;
      default: r = SEG_BLANK;
    endcase
    return r;
  endfunction

  assign mag_in_c = bin_in[WIDTH-1] ? (~bin_in + WIDTH'(1)) : bin_in;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (load) state_d = toggle ? LATCH : CONV;
      CONV:    if (cnt == CNT_W'(WIDTH - 1)) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One shift-add-3 step: correct nibbles >= 5, then shift in the next magnitude bit
  always_comb begin
    acc_adj_c = acc;
    nib_adj_c = 4'd0;
    for (int i = 0; i < int'(ACC_D); i++) begin
      nib_adj_c = acc[4*i +: 4];
      acc_adj_c[4*i +: 4] = (nib_adj_c >= 4'd5) ? (nib_adj_c + 4'd3) : nib_adj_c;
    end
    acc_sh_c = {acc_adj_c[ACC_W-2:0], mag[WIDTH-1]};
  end

  // Display image for the LATCH edge; leading zeros scanned from the top magnitude digit
  always_comb begin
    seg_d_c   = '1;
    ovf_d_c   = 1'b0;
    lead_c    = 1'b1;
    nib_fmt_c = 4'd0;
    if (mode_bcd) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        seg_d_c[7*i +: 7] = seg_code(bcd_q[4*i +: 4]);
      end
    end else begin
      ovf_d_c = |acc[ACC_W-1 -: OVF_W];
      if (ovf_d_c) begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          seg_d_c[7*i +: 7] = SEG_MINUS;
        end
      end else begin
        seg_d_c[SEG_W-1 -: 7] = neg ? SEG_MINUS : SEG_BLANK;
        for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
          nib_fmt_c = acc[4*i +: 4];
          if (BLANK_LZ && lead_c && (nib_fmt_c == 4'd0) && (i != 0)) begin
            seg_d_c[7*i +: 7] = SEG_BLANK;
          end else begin
            seg_d_c[7*i +: 7] = seg_code(nib_fmt_c);
            lead_c = 1'b0;
          end
        end
      end
    end
  end

  // Datapath and registered outputs; seg/ovf move only on the LATCH edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
      seg      <= '1;
      neg      <= 1'b0;
      mode_bcd <= 1'b0;
      mag      <= '0;
      acc      <= '0;
      bcd_q    <= '0;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            busy     <= 1'b1;
            valid    <= 1'b0;
            mode_bcd <= toggle;
            cnt      <= '0;
            if (toggle) begin
              bcd_q <= bcd_in;
            end else begin
              neg <= bin_in[WIDTH-1];
              mag <= mag_in_c;
              acc <= '0;
            end
          end
        end
        CONV: begin
          acc <= acc_sh_c;
          mag <= mag << 1;
          cnt <= cnt + CNT_W'(1);
        end
        LATCH: begin
          seg   <= seg_d_c;
          ovf   <= ovf_d_c;
          valid <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
